// File: rtl/oled_update_ctrl.sv
// oled_update_ctrl
//   Frame-update scheduler sharing one oled_serial driver between two pixel
//   sources. Round-robin arbitration on ties, frame starts rate-limited to
//   FRAME_HZ, per-attempt timeout, and up to MAX_RETRIES extra attempts
//   after a failed frame.
//
//   Optional build macro OLED_UPDATE_CTRL_STATS_EN enables the frame/error
//   statistics counters; without it out_frames/out_errors are tied to 0.
//
// Ports
//   in_clk, in_rst_n      clock, asynchronous active-low reset
//   in_req[1:0]           frame requests (sampled only in IDLE)
//   in_pixels0/1[7:0]     pixel bytes from requester 0 / 1
//   out_grant[1:0]        one-hot grant, held for the whole frame incl. retries
//   out_done/out_fail     one-cycle completion / give-up pulses (per requester)
//   out_pixels[7:0]       granted requester's pixel byte (combinational)
//   out_update            update strobe to the driver
//   in_serial_ready/error handshake/status from the driver
//   out_busy              high whenever not IDLE
//   out_frames/out_errors statistics (successful frames / failed attempts)
module oled_update_ctrl #(
  parameter int unsigned MAIN_CLK       = 27_000_000,
  parameter int unsigned FRAME_HZ       = 30,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned MAX_RETRIES    = 2
) (
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic [1:0]  in_req,
  input  logic [7:0]  in_pixels0,
  input  logic [7:0]  in_pixels1,
  output logic [1:0]  out_grant,
  output logic [1:0]  out_done,
  output logic [1:0]  out_fail,
  output logic [7:0]  out_pixels,
  output logic        out_update,
  input  logic        in_serial_ready,
  input  logic        in_serial_error,
  output logic        out_busy,
  output logic [15:0] out_frames,
  output logic [7:0]  out_errors
);

  localparam int unsigned HOLD = MAIN_CLK / FRAME_HZ;
  localparam int unsigned HW   = $clog2(HOLD + 1);
  localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RW   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_CHECK,
    S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            last_q, last_d;         // index of the last granted requester
  logic [RW-1:0]   retry_cnt_q, retry_cnt_d;
  logic            retry_q, retry_d;       // retry pending while in HOLD
  logic            tmo_q, tmo_d;           // current attempt ended by timeout
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic            update_q, update_d;
  logic [1:0]      done_q, done_d;
  logic [1:0]      fail_q, fail_d;
  logic            busy_q, busy_d;
  logic [1:0]      pick;
  logic            check_err;

  // Tie goes to the requester that was not granted last.
  assign pick      = (in_req == 2'b11) ? (last_q ? 2'b01 : 2'b10) : in_req;
  assign check_err = in_serial_error | tmo_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    retry_cnt_d = retry_cnt_q;
    retry_d     = retry_q;
    tmo_d       = 1'b0;
    hold_cnt_d  = (hold_cnt_q != '0) ? hold_cnt_q - HW'(1) : '0;
    to_cnt_d    = to_cnt_q;
    done_d      = '0;
    fail_d      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (hold_cnt_q == '0 && in_req != '0) begin
          grant_d     = pick;
          last_d      = pick[1];
          retry_cnt_d = RW'(MAX_RETRIES);
          retry_d     = 1'b0;
          state_d     = S_START;
        end
      end
      S_START: begin
        if (to_cnt_q == '0) begin
          tmo_d   = 1'b1;
          state_d = S_CHECK;
        end else begin
          to_cnt_d = to_cnt_q - TW'(1);
          if (!in_serial_ready) state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (to_cnt_q == '0) begin
          tmo_d   = 1'b1;
          state_d = S_CHECK;
        end else begin
          to_cnt_d = to_cnt_q - TW'(1);
          if (in_serial_ready) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = S_HOLD;
        retry_d = 1'b0;
        if (!check_err) begin
          done_d = grant_q;
        end else if (retry_cnt_q != '0) begin
          retry_cnt_d = retry_cnt_q - RW'(1);
          retry_d     = 1'b1;
        end else begin
          fail_d = grant_q;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == '0) begin
          if (retry_q) begin
            state_d = S_START;
          end else begin
            grant_d = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Both the holdoff and the timeout restart on every entry into START,
    // which covers first attempts and retries alike.
    if (state_d == S_START && state_q != S_START) begin
      hold_cnt_d = HW'(HOLD);
      to_cnt_d   = TW'(TIMEOUT_CYCLES);
    end

    update_d = (state_d == S_START);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      last_q      <= 1'b1;
      retry_cnt_q <= '0;
      retry_q     <= 1'b0;
      tmo_q       <= 1'b0;
      hold_cnt_q  <= '0;
      to_cnt_q    <= '0;
      update_q    <= 1'b0;
      done_q      <= '0;
      fail_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      retry_cnt_q <= retry_cnt_d;
      retry_q     <= retry_d;
      tmo_q       <= tmo_d;
      hold_cnt_q  <= hold_cnt_d;
      to_cnt_q    <= to_cnt_d;
      update_q    <= update_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    out_pixels = '0;
    if (grant_q[0])      out_pixels = in_pixels0;
    else if (grant_q[1]) out_pixels = in_pixels1;
  end

  assign out_grant  = grant_q;
  assign out_done   = done_q;
  assign out_fail   = fail_q;
  assign out_update = update_q;
  assign out_busy   = busy_q;

`ifdef OLED_UPDATE_CTRL_STATS_EN
  logic [15:0] frames_q, frames_d;
  logic [7:0]  errors_q, errors_d;

  // Every failed attempt counts, including ones that are retried later.
  always_comb begin
    frames_d = frames_q;
    errors_d = errors_q;
    if (state_q == S_CHECK) begin
      if (!check_err)              frames_d = frames_q + 16'd1;
      else if (errors_q != 8'hFF)  errors_d = errors_q + 8'd1;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      frames_q <= '0;
      errors_q <= '0;
    end else begin
      frames_q <= frames_d;
      errors_q <= errors_d;
    end
  end

  assign out_frames = frames_q;
  assign out_errors = errors_q;
`else
  assign out_frames = '0;
  assign out_errors = '0;
`endif

endmodule
